decoder_3x8_pulse: RTL and testbench
====================================

Name: decoder_3x8_pulse

Overview:
- Registered 3-to-8 decoder with a valid/ready handshake; the inverse of the team's 8x3 priority encoder.
- Accepts a 3-bit index and drives the matching one-hot output line for a programmable number of cycles, then holds off for a programmable gap.
- Keeps a sticky per-line "served" status mask.
- Used to return a grant/acknowledge pulse to the requester whose index the priority encoder produced.

Parameters:
HOLD_CYCLES, 4, cycles the one-hot output stays asserted per accepted code; legal 1..255
GAP_CYCLES, 1, idle cycles after a pulse before the next code is accepted; legal 0..255

Ports:
clk  input  1  single clock, rising edge
rst  input  1  reset, asynchronous, active-high
E  input  1  active-low enable; 1 = block disabled
code  input  3  index to decode
code_valid  input  1  code is valid this cycle
code_ready  output  1  block can accept code this cycle
Y  output  8  one-hot decoded output, registered
done  output  1  one-cycle pulse on the last asserted cycle of Y
served  output  8  sticky mask of indices accepted since reset/clear
clr  input  1  synchronous clear of served

Behaviour:
- One clock; reset is asynchronous and active-high. While rst=1: state=IDLE, Y=8'h00, done=0, served=8'h00, counter=0, code_ready=0.
- States: IDLE, DRIVE, GAP. Single 8-bit down-counter shared by DRIVE and GAP.
- code_ready = (state==IDLE) & !E & !rst. This is combinational. It does not depend on code_valid.
- Accept occurs at a rising edge when code_valid & code_ready. On accept:
  - latch code; go to DRIVE; counter <= HOLD_CYCLES-1;
  - Y <= 1<<code, so Y is visible the cycle after the accept edge (latency 1);
  - served[code] <= 1.
- DRIVE:
  - Y holds its value.
  - Each edge with counter!=0 decrements the counter.
  - done=1 combinationally while in DRIVE with counter==0, so Y is high for exactly HOLD_CYCLES cycles.
  - On the edge with counter==0: Y <= 0. Go to GAP with counter <= GAP_CYCLES-1, or go directly to IDLE if GAP_CYCLES==0.
- GAP:
  - Y=0 and code_ready=0.
  - Decrement the counter; on counter==0 go to IDLE. Gap length is exactly GAP_CYCLES cycles.
- Back-to-back with GAP_CYCLES=0: a new code can be accepted in the first IDLE cycle after Y drops. Y is then low for exactly 1 cycle between pulses.
- code/code_valid while not ready: ignored. No buffering; the sender must hold until the handshake completes.
- E=1 at any edge:
  - state <= IDLE, Y <= 0, counter <= 0, no done pulse;
  - an in-flight pulse is truncated;
  - served is unaffected.
  - E=1 forces code_ready=0 in the same cycle.
- clr=1 at an edge: served <= 8'h00, except that a bit set by an accept on the same edge ends at 1 (set wins).
- Y is always one-hot or zero. More than one bit set is an error; verification asserts against it.
- done never asserts while E=1 or in IDLE/GAP.
- Async reset mid-DRIVE: Y drops to 0 immediately, without waiting for an edge.

Test Plan:
- Reset, E=0, code=3'd5 valid for 1 cycle -> code_ready=1 at accept; Y=8'h20 for exactly 4 cycles starting next cycle; done high on the 4th; served=8'h20; code_ready low for 4+1 cycles, then high.
- Codes 0..7 issued back-to-back, each held until ready -> Y sequence 01,02,...,80, each 4 cycles wide with 1-cycle gaps; served=8'hFF; never two bits set.
- code=3'd2 accepted, E driven 1 on the 2nd Y cycle -> Y=00 next edge, no done pulse, code_ready=0 while E=1; after E=0, code_ready=1 immediately and served=8'h04.
- served=8'h04, clr=1 on the same edge as accepting code=3'd7 -> served=8'h80; clr alone next -> served=8'h00.
- HOLD_CYCLES=1, GAP_CYCLES=0, continuous valid with code=3'd1 -> Y toggles 02,00,02,00; done high every Y=02 cycle.
- rst pulsed asynchronously mid-DRIVE with Y=8'h10 -> Y=00, served=00, code_ready=0 without a clock edge; normal accept works after rst release.

Source files
------------

// File: rtl/decoder_3x8_pulse.sv
// rtl/decoder_3x8_pulse.sv - registered 3-to-8 decoder with timed one-hot pulse, gap and sticky served mask
//
// Ports:
//   clk         in   1  rising-edge clock
//   rst         in   1  asynchronous active-high reset
//   E           in   1  active-low enable (1 = disabled, truncates any pulse)
//   code        in   3  index to decode
//   code_valid  in   1  code is presented this cycle
//   code_ready  out  1  block accepts a code this cycle (IDLE, enabled, not in reset)
//   Y           out  8  registered one-hot output, held HOLD_CYCLES cycles per accept
//   done        out  1  high on the last cycle Y is asserted
//   served      out  8  sticky mask of accepted indices
//   clr         in   1  synchronous clear of served (a same-edge accept wins)

module decoder_3x8_pulse #(
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       E,
  input  logic [2:0] code,
  input  logic       code_valid,
  output logic       code_ready,
  output logic [7:0] Y,
  output logic       done,
  output logic [7:0] served,
  input  logic       clr
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRIVE = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  // Reload values for the shared down-counter; a zero gap never enters GAP,
  // so its reload is unused and simply kept in range.
  localparam logic [7:0] HOLD_RELOAD = 8'(HOLD_CYCLES - 1);
  localparam logic [7:0] GAP_RELOAD  = (GAP_CYCLES == 0) ? 8'd0 : 8'(GAP_CYCLES - 1);

  logic [1:0] state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] y_q, y_d;
  logic [7:0] served_q, served_d;
  logic       accept;
  logic       cnt_zero;

  assign code_ready = (state_q == ST_IDLE) & ~E & ~rst;
  assign accept     = code_valid & code_ready;
  assign cnt_zero   = (cnt_q == 8'd0);

  // Gated by E so a disable in the final DRIVE cycle never reports completion.
  assign done   = (state_q == ST_DRIVE) & cnt_zero & ~E;
  assign Y      = y_q;
  assign served = served_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    y_d     = y_q;

    if (E) begin
      state_d = ST_IDLE;
      cnt_d   = 8'd0;
      y_d     = 8'h00;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            state_d = ST_DRIVE;
            cnt_d   = HOLD_RELOAD;
            y_d     = 8'h01 << code;
          end
        end
        ST_DRIVE: begin
          if (!cnt_zero) begin
            cnt_d = cnt_q - 8'd1;
          end else begin
            y_d = 8'h00;
            if (GAP_CYCLES == 0) begin
              state_d = ST_IDLE;
              cnt_d   = 8'd0;
            end else begin
              state_d = ST_GAP;
              cnt_d   = GAP_RELOAD;
            end
          end
        end
        ST_GAP: begin
          if (cnt_zero) begin
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = 8'd0;
          y_d     = 8'h00;
        end
      endcase
    end
  end

  // Clear first, then the accept bit, so a set on the clearing edge survives.
  always_comb begin
    served_d = served_q;
    if (clr) begin
      served_d = 8'h00;
    end
    if (accept) begin
      served_d[code] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 8'd0;
      y_q      <= 8'h00;
      served_q <= 8'h00;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      y_q      <= y_d;
      served_q <= served_d;
    end
  end

endmodule

// File: tb/tb_decoder_3x8_pulse.sv
// tb/tb_decoder_3x8_pulse.sv - scoreboard bench for decoder_3x8_pulse

module tb_decoder_3x8_pulse;

  logic       clk = 1'b0;
  logic       rst, E, code_valid, clr;
  logic [2:0] code;
  logic       code_ready, done;
  logic [7:0] Y, served;

  logic       rst2, E2, code_valid2, clr2;
  logic [2:0] code2;
  logic       code_ready2, done2;
  logic [7:0] Y2, served2;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] y;
    int         len;
    bit         dn;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  decoder_3x8_pulse #(.HOLD_CYCLES(4), .GAP_CYCLES(1)) dut (
    .clk(clk), .rst(rst), .E(E), .code(code), .code_valid(code_valid),
    .code_ready(code_ready), .Y(Y), .done(done), .served(served), .clr(clr)
  );

  decoder_3x8_pulse #(.HOLD_CYCLES(1), .GAP_CYCLES(0)) dut2 (
    .clk(clk), .rst(rst2), .E(E2), .code(code2), .code_valid(code_valid2),
    .code_ready(code_ready2), .Y(Y2), .done(done2), .served(served2), .clr(clr2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Present a code and hold it until the handshake completes; the expected
  // pulse is queued at the moment the accept is known to happen.
  task automatic send(input logic [2:0] c, input int len, input bit dn);
    int n = 0;
    code       = c;
    code_valid = 1'b1;
    forever begin
      #1;
      if (code_ready) break;
      n++;
      if (n > 50) begin
        check("send_timeout", 32'd0, 32'd1);
        code_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    exp_q.push_back('{y: 8'h01 << c, len: len, dn: dn});
    @(posedge clk);
    @(negedge clk);
    code_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    #1;
    while (!code_ready) begin
      n++;
      if (n > 50) begin
        check("idle_timeout", 32'd0, 32'd1);
        return;
      end
      @(negedge clk);
      #1;
    end
  endtask

  // Monitor: measures each pulse on Y and compares it against the queue.
  bit         in_pulse = 0;
  logic [7:0] cur_y;
  int         cur_len, done_cnt;
  bit         done_last;

  always @(negedge clk) begin
    if (Y !== 8'h00) begin
      check("y_onehot", 32'($countones(Y)), 32'd1);
      if (!in_pulse) begin
        in_pulse  = 1;
        cur_y     = Y;
        cur_len   = 0;
        done_cnt  = 0;
        done_last = 0;
      end else begin
        check("y_stable", 32'(Y), 32'(cur_y));
      end
      cur_len++;
      if (done === 1'b1) done_cnt++;
      done_last = (done === 1'b1);
    end else begin
      check("done_when_y_low", 32'(done), 32'd0);
      if (in_pulse) begin
        in_pulse = 0;
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", 32'(cur_y), 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("pulse_y", 32'(cur_y), 32'(e.y));
          check("pulse_len", 32'(cur_len), 32'(e.len));
          check("pulse_done_cnt", 32'(done_cnt), e.dn ? 32'd1 : 32'd0);
          check("pulse_done_last", 32'(done_last), 32'(e.dn));
        end
      end
    end
  end

  // HOLD_CYCLES=1, GAP_CYCLES=0 instance with code 1 held valid continuously.
  initial begin
    logic [7:0] y_tab[4];
    logic       d_tab[4];
    y_tab = '{8'h02, 8'h00, 8'h02, 8'h00};
    d_tab = '{1'b1, 1'b0, 1'b1, 1'b0};
    rst2 = 1'b1; E2 = 1'b0; clr2 = 1'b0; code2 = 3'd1; code_valid2 = 1'b1;
    repeat (2) @(negedge clk);
    rst2 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      check("fast_y", 32'(Y2), 32'(y_tab[i]));
      check("fast_done", 32'(done2), 32'(d_tab[i]));
    end
    code_valid2 = 1'b0;
    check("fast_served", 32'(served2), 32'h02);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; E = 1'b0; code = 3'd0; code_valid = 1'b0; clr = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_y", 32'(Y), 32'h00);
    check("rst_done", 32'(done), 32'd0);
    check("rst_served", 32'(served), 32'h00);
    check("rst_ready", 32'(code_ready), 32'd0);
    rst = 1'b0;
    #1;
    check("ready_after_rst", 32'(code_ready), 32'd1);

    // Single code 5: ready low for 4 drive + 1 gap cycles.
    send(3'd5, 4, 1'b1);
    #1;
    check("served_5", 32'(served), 32'h20);
    for (int i = 0; i < 5; i++) begin
      check("ready_low_busy", 32'(code_ready), 32'd0);
      @(negedge clk);
      #1;
    end
    check("ready_back", 32'(code_ready), 32'd1);

    // All codes back-to-back.
    for (int c = 0; c < 8; c++) send(3'(c), 4, 1'b1);
    wait_idle();
    check("served_all", 32'(served), 32'hFF);

    // Clear alone.
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    #1;
    check("served_clr", 32'(served), 32'h00);

    // Disable during the 2nd cycle of a code-2 pulse.
    send(3'd2, 2, 1'b0);
    @(negedge clk);
    E = 1'b1;
    #1;
    check("e_ready", 32'(code_ready), 32'd0);
    check("e_done", 32'(done), 32'd0);
    @(negedge clk);
    #1;
    check("e_y_dropped", 32'(Y), 32'h00);
    check("e_ready_held", 32'(code_ready), 32'd0);
    E = 1'b0;
    #1;
    check("e_ready_release", 32'(code_ready), 32'd1);
    check("e_served", 32'(served), 32'h04);

    // Clear on the same edge as accepting code 7: set wins.
    clr = 1'b1;
    send(3'd7, 4, 1'b1);
    clr = 1'b0;
    #1;
    check("clr_set_wins", 32'(served), 32'h80);
    wait_idle();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    #1;
    check("clr_alone", 32'(served), 32'h00);

    // Asynchronous reset in the middle of a code-4 pulse.
    wait_idle();
    send(3'd4, 1, 1'b0);
    #1;
    check("pre_rst_y", 32'(Y), 32'h10);
    #1;
    rst = 1'b1;
    #1;
    check("async_y", 32'(Y), 32'h00);
    check("async_served", 32'(served), 32'h00);
    check("async_ready", 32'(code_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    send(3'd3, 4, 1'b1);
    wait_idle();
    check("post_rst_served", 32'(served), 32'h08);

    repeat (3) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    check("no_open_pulse", 32'(in_pulse), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
